// File: rtl/mem_responder_if.sv
// mem_responder_if: CPU split i/d memory ports and the shared physical
// memory port, bundled for the mem_responder. The responder connects
// through the slave modport; the core/memory side uses the master modport.
interface mem_responder_if;
  logic [31:0] i_mem_addr;
  logic        i_mem_read;
  logic [31:0] i_mem_rdata;
  logic        i_mem_resp;

  logic [31:0] d_mem_addr;
  logic        d_mem_read;
  logic        d_mem_write;
  logic [31:0] d_mem_wdata;
  logic [3:0]  d_mem_byte_enable;
  logic [31:0] d_mem_rdata;
  logic        d_mem_resp;

  logic [31:0] pmem_addr;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_wdata;
  logic [3:0]  pmem_byte_enable;
  logic [31:0] pmem_rdata;
  logic        pmem_resp;

  modport slave (
    input  i_mem_addr, i_mem_read,
    output i_mem_rdata, i_mem_resp,
    input  d_mem_addr, d_mem_read, d_mem_write, d_mem_wdata, d_mem_byte_enable,
    output d_mem_rdata, d_mem_resp,
    output pmem_addr, pmem_read, pmem_write, pmem_wdata, pmem_byte_enable,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output i_mem_addr, i_mem_read,
    input  i_mem_rdata, i_mem_resp,
    output d_mem_addr, d_mem_read, d_mem_write, d_mem_wdata, d_mem_byte_enable,
    input  d_mem_rdata, d_mem_resp,
    input  pmem_addr, pmem_read, pmem_write, pmem_wdata, pmem_byte_enable,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: serializes the core's instruction-fetch and data-access
// requests onto a single word-wide, variable-latency physical memory port.
// One access is in flight at a time; completion is a one-cycle resp pulse
// carrying registered read data back to the side that was granted.
// Build option: define MEM_RESPONDER_RR_ARB_EN for round-robin arbitration
// on simultaneous requests; left undefined, the d-side always wins ties.
module mem_responder (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave mem_if
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;    // word address of the granted access
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        write_q, write_d;
  logic        side_q, side_d;    // 1: d-side owns the access
  logic [31:0] rdata_q, rdata_d;

  logic i_vld;
  logic d_vld;
  logic grant_dside;
  logic unused_addr_lsbs;

`ifdef MEM_RESPONDER_RR_ARB_EN
  logic last_grant_q, last_grant_d; // 1: d-side was granted last
`endif

  assign i_vld = mem_if.i_mem_read;
  // Read and write together is malformed and treated as no d request.
  assign d_vld = mem_if.d_mem_read ^ mem_if.d_mem_write;

`ifdef MEM_RESPONDER_RR_ARB_EN
  assign grant_dside = d_vld & (~i_vld | ~last_grant_q);
`else
  assign grant_dside = d_vld;
`endif

  // Byte offsets are dropped: the physical port is word addressed.
  assign unused_addr_lsbs = ^{mem_if.i_mem_addr[1:0], mem_if.d_mem_addr[1:0]};

  // Next-state, request capture and output decode.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    write_d = write_q;
    side_d  = side_q;
    rdata_d = rdata_q;
`ifdef MEM_RESPONDER_RR_ARB_EN
    last_grant_d = last_grant_q;
`endif
    mem_if.i_mem_rdata      = '0;
    mem_if.i_mem_resp       = 1'b0;
    mem_if.d_mem_rdata      = '0;
    mem_if.d_mem_resp       = 1'b0;
    mem_if.pmem_addr        = '0;
    mem_if.pmem_read        = 1'b0;
    mem_if.pmem_write       = 1'b0;
    mem_if.pmem_wdata       = '0;
    mem_if.pmem_byte_enable = '0;

    unique case (state_q)
      IDLE: begin
        if (i_vld || d_vld) begin
          state_d = ISSUE;
          side_d  = grant_dside;
`ifdef MEM_RESPONDER_RR_ARB_EN
          last_grant_d = grant_dside;
`endif
          if (grant_dside) begin
            addr_d  = mem_if.d_mem_addr[31:2];
            write_d = mem_if.d_mem_write;
            wdata_d = mem_if.d_mem_write ? mem_if.d_mem_wdata : '0;
            be_d    = mem_if.d_mem_write ? mem_if.d_mem_byte_enable : 4'hF;
          end else begin
            addr_d  = mem_if.i_mem_addr[31:2];
            write_d = 1'b0;
            wdata_d = '0;
            be_d    = 4'hF;
          end
        end
      end
      ISSUE: begin
        // The pmem port is driven only from the captured request so it
        // stays stable even if the core's inputs move.
        mem_if.pmem_addr        = {addr_q, 2'b00};
        mem_if.pmem_read        = ~write_q;
        mem_if.pmem_write       = write_q;
        mem_if.pmem_wdata       = wdata_q;
        mem_if.pmem_byte_enable = be_q;
        if (mem_if.pmem_resp) begin
          rdata_d = write_q ? '0 : mem_if.pmem_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        // No re-grant here: the core still shows the request just served.
        if (side_q) begin
          mem_if.d_mem_resp  = 1'b1;
          mem_if.d_mem_rdata = rdata_q;
        end else begin
          mem_if.i_mem_resp  = 1'b1;
          mem_if.i_mem_rdata = rdata_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request/response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      write_q <= 1'b0;
      side_q  <= 1'b0;
      rdata_q <= '0;
`ifdef MEM_RESPONDER_RR_ARB_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      write_q <= write_d;
      side_q  <= side_d;
      rdata_q <= rdata_d;
`ifdef MEM_RESPONDER_RR_ARB_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

endmodule
